// File: rtl/sc_pwm_pkg.sv
// Shared types and helpers for the PWM ramp driver: state encoding, the
// dead-time counter width and the saturating step used by the slew path.
package sc_pwm_pkg;

   localparam int DEAD_CNT_W = 4;
   // Step arithmetic is one bit wider than the widest supported duty (N <= 16).
   localparam int SAT_W = 17;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DOWN = 2'd1,
      ST_DEAD = 2'd2
   } pwm_state_e;

   function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] cur,
                                                  input logic [SAT_W-1:0] tgt,
                                                  input logic [SAT_W-1:0] step);
      logic [SAT_W-1:0] res;
      if (cur < tgt) begin
         res = cur + step;
         if (res > tgt) res = tgt;
      end else if (cur > tgt) begin
         res = ((cur - tgt) > step) ? (cur - step) : tgt;
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/sc_pwm_slew_step.sv
// Combinational saturating step of an N-bit value toward a goal by at most STEP.
module sc_pwm_slew_step
   import sc_pwm_pkg::*;
#(
   parameter int N    = 8,
   parameter int STEP = 16
) (
   input  logic [N-1:0] cur,
   input  logic [N-1:0] tgt,
   output logic [N-1:0] nxt
);

   logic [SAT_W-1:0] full;

   // The result never exceeds max(cur, tgt); the upper-bit fold only pins an
   // impossible overflow to all-ones rather than letting it wrap.
   always_comb begin
      full = sat_step(SAT_W'(cur), SAT_W'(tgt), SAT_W'(STEP));
      nxt  = full[N-1:0] | {N{|full[SAT_W-1:N]}};
   end

endmodule

// File: rtl/sc_pwm_ramp_driver.sv
// Motor-channel duty controller: slews duty toward a clamped target once per
// PWM period, reverses direction through ramp-down and dead time, drives PWM/DIR.
//
// state | meaning
// RUN   | duty tracks target; a direction mismatch starts the reversal
// DOWN  | reversal pending, duty ramping to 0
// DEAD  | duty 0, PWM forced low, counting dead periods before DIR swap
module sc_pwm_ramp_driver
   import sc_pwm_pkg::*;
#(
   parameter int N            = 8,
   parameter int STEP         = 16,
   parameter int MAX_DUTY     = (1 << N) - 16,
   parameter int DEAD_PERIODS = 2
) (
   input  logic         SC_COUNTER_PWM_CLOCK,
   input  logic         SC_COUNTER_PWM_RESET_InHigh,
   input  logic [N-1:0] SC_PWM_RAMP_TARGET_InBus,
   input  logic         SC_PWM_RAMP_TARGETDIR_In,
   input  logic         SC_PWM_RAMP_LOAD_InLow,
   input  logic         SC_PWM_RAMP_STOP_InLow,
   input  logic [N-1:0] SC_PWM_RAMP_REGCOUNT_InBus,
   input  logic         SC_PWM_RAMP_ENDCOUNT_InLow,
   output logic [N-1:0] SC_PWM_RAMP_FLAGCOMP_OutBus,
   output logic         SC_PWM_RAMP_PWM_Out,
   output logic         SC_PWM_RAMP_DIR_Out,
   output logic         SC_PWM_RAMP_ATTARGET_OutLow
);

   localparam logic [N-1:0]          MAX_DUTY_N = N'(MAX_DUTY);
   localparam logic [DEAD_CNT_W-1:0] DEAD_LAST  = DEAD_CNT_W'(DEAD_PERIODS - 1);

   logic [N-1:0]          duty_q, duty_d;
   logic [N-1:0]          target_q, target_d;
   logic                  tdir_q, tdir_d;
   logic                  dir_q, dir_d;
   pwm_state_e            state_q, state_d;
   logic [DEAD_CNT_W-1:0] dead_cnt_q, dead_cnt_d;

   logic [N-1:0] run_step;
   logic [N-1:0] down_step;

   sc_pwm_slew_step #(.N(N), .STEP(STEP)) u_run_step (
      .cur (duty_q),
      .tgt (target_q),
      .nxt (run_step)
   );

   sc_pwm_slew_step #(.N(N), .STEP(STEP)) u_down_step (
      .cur (duty_q),
      .tgt ('0),
      .nxt (down_step)
   );

   always_comb begin
      duty_d     = duty_q;
      target_d   = target_q;
      tdir_d     = tdir_q;
      dir_d      = dir_q;
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      if (!SC_PWM_RAMP_STOP_InLow) begin
         duty_d     = '0;
         target_d   = '0;
         state_d    = ST_RUN;
         dead_cnt_d = '0;
      end else begin
         if (!SC_PWM_RAMP_LOAD_InLow) begin
            target_d = (SC_PWM_RAMP_TARGET_InBus > MAX_DUTY_N) ? MAX_DUTY_N
                                                               : SC_PWM_RAMP_TARGET_InBus;
            tdir_d   = SC_PWM_RAMP_TARGETDIR_In;
         end
         // Step decisions use the pre-load target; a same-edge load lands next period.
         if (!SC_PWM_RAMP_ENDCOUNT_InLow) begin
            case (state_q)
               ST_RUN: begin
                  if (tdir_q == dir_q) begin
                     duty_d = run_step;
                  end else if (duty_q == '0) begin
                     state_d    = ST_DEAD;
                     dead_cnt_d = '0;
                  end else begin
                     duty_d     = down_step;
                     state_d    = (down_step == '0) ? ST_DEAD : ST_DOWN;
                     dead_cnt_d = '0;
                  end
               end
               ST_DOWN: begin
                  if (tdir_q == dir_q) begin
                     state_d = ST_RUN;
                  end else begin
                     duty_d = down_step;
                     if (down_step == '0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = '0;
                     end
                  end
               end
               ST_DEAD: begin
                  duty_d = '0;
                  if (dead_cnt_q == DEAD_LAST) begin
                     dir_d      = tdir_q;
                     state_d    = ST_RUN;
                     dead_cnt_d = '0;
                  end else begin
                     dead_cnt_d = dead_cnt_q + 1'b1;
                  end
               end
               default: begin
                  duty_d  = '0;
                  state_d = ST_RUN;
               end
            endcase
         end
      end
   end

   always_ff @(posedge SC_COUNTER_PWM_CLOCK or posedge SC_COUNTER_PWM_RESET_InHigh) begin
      if (SC_COUNTER_PWM_RESET_InHigh) begin
         duty_q     <= '0;
         target_q   <= '0;
         tdir_q     <= 1'b0;
         dir_q      <= 1'b0;
         state_q    <= ST_RUN;
         dead_cnt_q <= '0;
      end else begin
         duty_q     <= duty_d;
         target_q   <= target_d;
         tdir_q     <= tdir_d;
         dir_q      <= dir_d;
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
      end
   end

   // STOP gates PWM combinationally so the pin drops before the next edge.
   assign SC_PWM_RAMP_PWM_Out = (SC_PWM_RAMP_REGCOUNT_InBus < duty_q) &&
                                (state_q != ST_DEAD) && SC_PWM_RAMP_STOP_InLow;
   assign SC_PWM_RAMP_FLAGCOMP_OutBus = duty_q;
   assign SC_PWM_RAMP_DIR_Out         = dir_q;
   assign SC_PWM_RAMP_ATTARGET_OutLow = !((state_q == ST_RUN) && (dir_q == tdir_q) &&
                                          (duty_q == target_q));

endmodule

// File: tb/tb_sc_pwm_ramp_driver.sv
// Directed bench for sc_pwm_ramp_driver with a free-running 8-bit period counter.
module tb_sc_pwm_ramp_driver;

   logic       clk;
   logic       rst;
   logic [7:0] target;
   logic       tdir;
   logic       load_n;
   logic       stop_n;
   logic [7:0] count;
   logic       end_n;
   logic [7:0] flagcomp;
   logic       pwm;
   logic       dir;
   logic       attarget_n;

   int total = 0;
   int bad   = 0;

   sc_pwm_ramp_driver #(.N(8), .STEP(16), .MAX_DUTY(240), .DEAD_PERIODS(2)) dut (
      .SC_COUNTER_PWM_CLOCK        (clk),
      .SC_COUNTER_PWM_RESET_InHigh (rst),
      .SC_PWM_RAMP_TARGET_InBus    (target),
      .SC_PWM_RAMP_TARGETDIR_In    (tdir),
      .SC_PWM_RAMP_LOAD_InLow      (load_n),
      .SC_PWM_RAMP_STOP_InLow      (stop_n),
      .SC_PWM_RAMP_REGCOUNT_InBus  (count),
      .SC_PWM_RAMP_ENDCOUNT_InLow  (end_n),
      .SC_PWM_RAMP_FLAGCOMP_OutBus (flagcomp),
      .SC_PWM_RAMP_PWM_Out         (pwm),
      .SC_PWM_RAMP_DIR_Out         (dir),
      .SC_PWM_RAMP_ATTARGET_OutLow (attarget_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) count <= 8'd0;
      else     count <= count + 8'd1;
   end
   assign end_n = (count != 8'hFF);

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   // Advance until the period boundary edge has just been taken (count now 0).
   task automatic wait_tick();
      bit found = 0;
      for (int i = 0; i < 300; i++) begin
         if (count == 8'hFF) begin
            found = 1;
            break;
         end
         step_cycle();
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL tick_timeout: no end-of-period seen within 300 cycles");
      end
      step_cycle();
   endtask

   task automatic do_load(input logic [7:0] t, input logic d);
      target = t;
      tdir   = d;
      load_n = 1'b0;
      step_cycle();
      load_n = 1'b1;
   endtask

   task automatic test_reset();
      int highs;
      do_load(8'd100, 1'b0);
      wait_tick();
      wait_tick();
      for (int i = 0; i < 10; i++) step_cycle();
      total++;
      if (pwm !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_pwm: got %0b want 1 (count=%0d duty=%0d)", pwm, count, flagcomp);
      end
      rst = 1'b1;
      #2;
      total++;
      if (flagcomp !== 8'd0) begin bad++; $display("FAIL reset_flagcomp: got %0d want 0", flagcomp); end
      total++;
      if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %0b want 0", pwm); end
      total++;
      if (dir !== 1'b0) begin bad++; $display("FAIL reset_dir: got %0b want 0", dir); end
      total++;
      if (attarget_n !== 1'b0) begin bad++; $display("FAIL reset_attarget: got %0b want 0", attarget_n); end
      #1;
      rst = 1'b0;
      highs = 0;
      for (int i = 0; i < 300; i++) begin
         step_cycle();
         if (pwm === 1'b1 || flagcomp !== 8'd0) highs++;
      end
      total++;
      if (highs != 0) begin bad++; $display("FAIL reset_after_run: %0d active cycles, want 0", highs); end
   endtask

   task automatic test_ramp();
      logic [7:0] exp_duty [7] = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
      int highs;
      int shape_err;
      do_load(8'd100, 1'b0);
      for (int i = 0; i < 7; i++) begin
         wait_tick();
         total++;
         if (flagcomp !== exp_duty[i]) begin
            bad++;
            $display("FAIL ramp_duty[%0d]: got %0d want %0d", i, flagcomp, exp_duty[i]);
         end
         total++;
         if (attarget_n !== (i == 6 ? 1'b0 : 1'b1)) begin
            bad++;
            $display("FAIL ramp_attarget[%0d]: got %0b want %0b", i, attarget_n, (i == 6 ? 1'b0 : 1'b1));
         end
      end
      highs = 0;
      shape_err = 0;
      for (int i = 0; i < 256; i++) begin
         if (pwm === 1'b1) highs++;
         if (pwm !== (count < 8'd100)) shape_err++;
         step_cycle();
      end
      total++;
      if (highs != 100) begin bad++; $display("FAIL ramp_pwm_highs: got %0d want 100", highs); end
      total++;
      if (shape_err != 0) begin bad++; $display("FAIL ramp_pwm_shape: %0d wrong cycles, want 0", shape_err); end
   endtask

   task automatic test_clamp();
      int e;
      do_load(8'd255, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         wait_tick();
         e = 100 + 16 * i;
         if (e > 240) e = 240;
         total++;
         if (flagcomp !== 8'(e)) begin
            bad++;
            $display("FAIL clamp_duty[%0d]: got %0d want %0d", i, flagcomp, e);
         end
      end
      total++;
      if (attarget_n !== 1'b0) begin bad++; $display("FAIL clamp_attarget: got %0b want 0", attarget_n); end
   endtask

   task automatic test_reverse();
      logic [7:0] exp_duty [8] = '{8'd24, 8'd8, 8'd0, 8'd0, 8'd0, 8'd16, 8'd32, 8'd40};
      logic       exp_dir  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic       exp_at   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int e;
      do_load(8'd40, 1'b0);
      for (int i = 1; i <= 13; i++) begin
         wait_tick();
         e = 240 - 16 * i;
         if (e < 40) e = 40;
         total++;
         if (flagcomp !== 8'(e)) begin
            bad++;
            $display("FAIL down_to_40[%0d]: got %0d want %0d", i, flagcomp, e);
         end
      end
      do_load(8'd40, 1'b1);
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         total++;
         if (flagcomp !== exp_duty[i]) begin
            bad++;
            $display("FAIL rev_duty[%0d]: got %0d want %0d", i, flagcomp, exp_duty[i]);
         end
         total++;
         if (dir !== exp_dir[i]) begin
            bad++;
            $display("FAIL rev_dir[%0d]: got %0b want %0b", i, dir, exp_dir[i]);
         end
         total++;
         if (attarget_n !== exp_at[i]) begin
            bad++;
            $display("FAIL rev_attarget[%0d]: got %0b want %0b", i, attarget_n, exp_at[i]);
         end
      end
   endtask

   task automatic test_stop();
      do_load(8'd200, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         wait_tick();
         total++;
         if (flagcomp !== 8'(40 + 16 * i)) begin
            bad++;
            $display("FAIL up_to_200[%0d]: got %0d want %0d", i, flagcomp, 40 + 16 * i);
         end
      end
      for (int i = 0; i < 50; i++) step_cycle();
      total++;
      if (pwm !== 1'b1) begin bad++; $display("FAIL stop_pre_pwm: got %0b want 1 (count=%0d)", pwm, count); end
      stop_n = 1'b0;
      #1;
      total++;
      if (pwm !== 1'b0) begin bad++; $display("FAIL stop_comb_pwm: got %0b want 0", pwm); end
      step_cycle();
      total++;
      if (flagcomp !== 8'd0) begin bad++; $display("FAIL stop_flagcomp: got %0d want 0", flagcomp); end
      total++;
      if (dir !== 1'b1) begin bad++; $display("FAIL stop_dir_kept: got %0b want 1", dir); end
      do_load(8'd100, 1'b0);
      step_cycle();
      stop_n = 1'b1;
      wait_tick();
      wait_tick();
      total++;
      if (flagcomp !== 8'd0) begin bad++; $display("FAIL stop_load_ignored_duty: got %0d want 0", flagcomp); end
      total++;
      if (attarget_n !== 1'b0) begin bad++; $display("FAIL stop_load_ignored_at: got %0b want 0", attarget_n); end
   endtask

   task automatic test_same_edge();
      do_load(8'd100, 1'b1);
      wait_tick();
      total++;
      if (flagcomp !== 8'd16) begin bad++; $display("FAIL same_edge_pre: got %0d want 16", flagcomp); end
      for (int i = 0; i < 300 && count != 8'hFF; i++) step_cycle();
      do_load(8'd20, 1'b1);
      total++;
      if (flagcomp !== 8'd32) begin bad++; $display("FAIL same_edge_old_target: got %0d want 32", flagcomp); end
      wait_tick();
      total++;
      if (flagcomp !== 8'd20) begin bad++; $display("FAIL same_edge_new_target: got %0d want 20", flagcomp); end
      total++;
      if (attarget_n !== 1'b0) begin bad++; $display("FAIL same_edge_attarget: got %0b want 0", attarget_n); end
   endtask

   initial begin
      rst    = 1'b1;
      target = 8'd0;
      tdir   = 1'b0;
      load_n = 1'b1;
      stop_n = 1'b1;
      #12;
      rst = 1'b0;
      step_cycle();
      test_reset();
      test_ramp();
      test_clamp();
      test_reverse();
      test_stop();
      test_same_edge();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
